branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the five-stage pipelined RISC-V core. It replaces the static not-taken policy, in which the ID-stage equality compare flushes IF/ID on every taken branch. The block sits beside the PC and is indexed combinationally by the IF-stage PC. It holds a direct-mapped table of tagged entries, each with a saturating counter and a branch target, and is trained by the ID stage once the branch resolves. It also keeps running statistics of updates and mispredictions.

---
 rtl/bp_pkg.sv | 50 +++++
 rtl/bp_sat_counter.sv | 28 ++
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared helpers for the dynamic branch predictor.
// Holds the counter reference points (weakly not-taken, weakly taken), the
// counter saturation limits, and the PC index/tag extraction functions.
// The table entry struct is declared alongside as a width-generic template
// (entry_fields_t); the top module instantiates it with its own widths.
package bp_pkg;

    // Width of the running statistic counters.
    localparam int unsigned CNT_W = 32;

    // Weakly not-taken: 2^(ctr_w-1)-1 (0 when ctr_w = 1).
    function automatic int unsigned ctr_wnt(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // Weakly taken: 2^(ctr_w-1).
    function automatic int unsigned ctr_wt(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    // Saturation limits of a ctr_w-bit counter.
    function automatic int unsigned ctr_max(input int unsigned ctr_w);
        return (32'd1 << ctr_w) - 32'd1;
    endfunction

    function automatic int unsigned ctr_min(input int unsigned ctr_w);
        return ctr_w - ctr_w;
    endfunction

    // Index = pc[idx_w+1:2]; the low two PC bits never take part.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag = pc[XLEN-1:idx_w+2]; the caller truncates to its tag width.
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

    // Field layout of a table entry at the largest supported widths
    // (XLEN up to 64, CTR_W up to 4). The top module declares a packed
    // struct with exactly this field order sized to its parameters.
    typedef struct packed {
        logic        valid;
        logic [63:0] tag;
        logic [63:0] target;
        logic [3:0]  ctr;
    } entry_fields_t;

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational up/down saturating counter step.
// Ports:
//   ctr      in  CTR_W  current counter value
//   dir      in  1      1 = count up (taken), 0 = count down (not taken)
//   ctr_next out CTR_W  next value, clamped to [0, 2^CTR_W-1]
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             dir,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] Max = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] Min = CTR_W'(ctr_min(CTR_W));

    always_comb begin
        ctr_next = ctr;
        if (dir) begin
            if (ctr != Max) ctr_next = ctr + CTR_W'(1);
        end else begin
            if (ctr != Min) ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped, tagged dynamic branch predictor.
// Lookup is combinational from the IF-stage PC; training comes from the ID
// stage when a conditional branch resolves. Also counts updates and
// mispredictions (both saturating).
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_pc_i                  fetch PC to look up
//   pred_hit_o/taken_o       hit, predicted direction (hit && ctr MSB)
//   pred_target_o            stored target on hit, else 0
//   upd_valid_i/pc_i         a branch resolved this cycle, and its PC
//   upd_taken_i/target_i     actual direction and taken target
//   upd_cnt_o, mispred_cnt_o statistics
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    output logic [CNT_W-1:0] upd_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int unsigned      TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] Wnt   = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] Wt    = CTR_W'(ctr_wt(CTR_W));

    // Same field order as bp_pkg::entry_fields_t, sized to this instance.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t           table_q [ENTRIES];
    logic [CNT_W-1:0] upd_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    // Lookup path.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    entry_t           if_entry;

    assign if_idx   = IDX_W'(pc_index(64'(if_pc_i), IDX_W));
    assign if_tag   = TAG_W'(pc_tag(64'(if_pc_i), IDX_W));
    assign if_entry = table_q[if_idx];

    always_comb begin
        pred_hit_o    = if_entry.valid && (if_entry.tag == if_tag);
        pred_taken_o  = pred_hit_o && if_entry.ctr[CTR_W-1];
        pred_target_o = pred_hit_o ? if_entry.target : '0;
    end

    // Update path, judged against the table as it stands now.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_entry;
    logic             upd_hit;
    logic             upd_pred_taken;
    logic             mispred;
    logic [CTR_W-1:0] ctr_next;

    assign upd_idx   = IDX_W'(pc_index(64'(upd_pc_i), IDX_W));
    assign upd_tag   = TAG_W'(pc_tag(64'(upd_pc_i), IDX_W));
    assign upd_entry = table_q[upd_idx];

    always_comb begin
        upd_hit        = upd_entry.valid && (upd_entry.tag == upd_tag);
        upd_pred_taken = upd_entry.ctr[CTR_W-1];
        mispred        = 1'b0;
        if (!upd_hit) begin
            mispred = upd_taken_i;
        end else if (upd_pred_taken != upd_taken_i) begin
            mispred = 1'b1;
        end else if (upd_taken_i && (upd_entry.target != upd_target_i)) begin
            mispred = 1'b1;
        end
    end

    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr      (upd_entry.ctr),
        .dir      (upd_taken_i),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: Wnt};
            end
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                table_q[upd_idx].ctr <= ctr_next;
                if (upd_taken_i) table_q[upd_idx].target <= upd_target_i;
            end else if (upd_taken_i) begin
                // Allocation simply evicts whatever aliases at this index.
                table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i, ctr: Wt};
            end
            if (upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 32'd1;
            if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign upd_cnt_o     = upd_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. Two instances share stimulus:
// dut_a (ENTRIES = 64, CTR_W = 2) and dut_b (ENTRIES = 4, CTR_W = 1).
// 0x100, 0x200 and 0x300 all map to index 0 in both configurations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    logic        hit_a, taken_a, hit_b, taken_b;
    logic [31:0] tgt_a, tgt_b, ucnt_a, ucnt_b, mcnt_a, mcnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .ENTRIES(64), .CTR_W(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
        .pred_hit_o(hit_a), .pred_taken_o(taken_a), .pred_target_o(tgt_a),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_cnt_o(ucnt_a), .mispred_cnt_o(mcnt_a)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(4), .CTR_W(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
        .pred_hit_o(hit_b), .pred_taken_o(taken_b), .pred_target_o(tgt_b),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_cnt_o(ucnt_b), .mispred_cnt_o(mcnt_b)
    );

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle update pulse, then looking at 0x100 by default.
    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        tick();
        upd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        if_pc = 32'h100;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL reset_hit_a got %0b want 0", hit_a); end
        checks++; if (taken_a !== 1'b0) begin errors++; $display("FAIL reset_taken_a got %0b want 0", taken_a); end
        checks++; if (tgt_a !== 32'h0) begin errors++; $display("FAIL reset_tgt_a got %h want 0", tgt_a); end
        checks++; if (ucnt_a !== 32'd0 || mcnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt_a got %0d/%0d want 0/0", ucnt_a, mcnt_a); end
        checks++; if (hit_b !== 1'b0 || taken_b !== 1'b0 || tgt_b !== 32'h0) begin errors++; $display("FAIL reset_pred_b got %0b/%0b/%h want 0/0/0", hit_b, taken_b, tgt_b); end
        checks++; if (ucnt_b !== 32'd0 || mcnt_b !== 32'd0) begin errors++; $display("FAIL reset_cnt_b got %0d/%0d want 0/0", ucnt_b, mcnt_b); end
    endtask

    task automatic test_train();
        do_update(32'h100, 1'b1, 32'h80);
        checks++; if (hit_a !== 1'b1 || taken_a !== 1'b1 || tgt_a !== 32'h80) begin errors++; $display("FAIL train_pred_a got %0b/%0b/%h want 1/1/80", hit_a, taken_a, tgt_a); end
        checks++; if (hit_b !== 1'b1 || taken_b !== 1'b1 || tgt_b !== 32'h80) begin errors++; $display("FAIL train_pred_b got %0b/%0b/%h want 1/1/80", hit_b, taken_b, tgt_b); end
        checks++; if (ucnt_a !== 32'd1 || mcnt_a !== 32'd1) begin errors++; $display("FAIL train_cnt_a got %0d/%0d want 1/1", ucnt_a, mcnt_a); end
        checks++; if (ucnt_b !== 32'd1 || mcnt_b !== 32'd1) begin errors++; $display("FAIL train_cnt_b got %0d/%0d want 1/1", ucnt_b, mcnt_b); end
    endtask

    // Three not-taken updates: only the first is a misprediction; the
    // counter floors at 0 rather than wrapping.
    task automatic test_not_taken_saturate();
        logic [31:0] exp_u;
        for (int i = 0; i < 3; i++) begin
            do_update(32'h100, 1'b0, 32'h0);
            exp_u = 32'(i + 2);
            checks++; if (hit_a !== 1'b1 || taken_a !== 1'b0) begin errors++; $display("FAIL nt%0d_pred_a got %0b/%0b want 1/0", i, hit_a, taken_a); end
            checks++; if (hit_b !== 1'b1 || taken_b !== 1'b0) begin errors++; $display("FAIL nt%0d_pred_b got %0b/%0b want 1/0", i, hit_b, taken_b); end
            checks++; if (ucnt_a !== exp_u || mcnt_a !== 32'd2) begin errors++; $display("FAIL nt%0d_cnt_a got %0d/%0d want %0d/2", i, ucnt_a, mcnt_a, exp_u); end
            checks++; if (ucnt_b !== exp_u || mcnt_b !== 32'd2) begin errors++; $display("FAIL nt%0d_cnt_b got %0d/%0d want %0d/2", i, ucnt_b, mcnt_b, exp_u); end
        end
    endtask

    // From ctr = 0, one taken update: A -> 1 (still not-taken), B -> 1 (taken).
    task automatic test_taken_recover();
        do_update(32'h100, 1'b1, 32'h84);
        checks++; if (taken_a !== 1'b0 || tgt_a !== 32'h84) begin errors++; $display("FAIL recover_a got %0b/%h want 0/84", taken_a, tgt_a); end
        checks++; if (taken_b !== 1'b1 || tgt_b !== 32'h84) begin errors++; $display("FAIL recover_b got %0b/%h want 1/84", taken_b, tgt_b); end
        checks++; if (mcnt_a !== 32'd3 || mcnt_b !== 32'd3 || ucnt_a !== 32'd5) begin errors++; $display("FAIL recover_cnt got %0d/%0d/%0d want 3/3/5", mcnt_a, mcnt_b, ucnt_a); end
    endtask

    // Lookup and update of the same entry in one cycle: no bypass.
    task automatic test_same_cycle();
        if_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h84;
        #1;
        checks++; if (taken_a !== 1'b0) begin errors++; $display("FAIL same_pre_a got %0b want 0", taken_a); end
        checks++; if (taken_b !== 1'b1) begin errors++; $display("FAIL same_pre_b got %0b want 1", taken_b); end
        tick();
        upd_valid = 1'b0;
        #1;
        checks++; if (taken_a !== 1'b1) begin errors++; $display("FAIL same_post_a got %0b want 1", taken_a); end
        checks++; if (mcnt_a !== 32'd4 || mcnt_b !== 32'd3) begin errors++; $display("FAIL same_mp got %0d/%0d want 4/3", mcnt_a, mcnt_b); end
        checks++; if (ucnt_a !== 32'd6 || ucnt_b !== 32'd6) begin errors++; $display("FAIL same_upd got %0d/%0d want 6/6", ucnt_a, ucnt_b); end
    endtask

    // Target mismatch with agreeing direction, upper saturation, step down.
    task automatic test_target_and_top();
        do_update(32'h100, 1'b1, 32'h90);
        checks++; if (mcnt_a !== 32'd5 || mcnt_b !== 32'd4) begin errors++; $display("FAIL tgt_mp got %0d/%0d want 5/4", mcnt_a, mcnt_b); end
        checks++; if (tgt_a !== 32'h90 || tgt_b !== 32'h90) begin errors++; $display("FAIL tgt_val got %h/%h want 90/90", tgt_a, tgt_b); end
        do_update(32'h100, 1'b1, 32'h90);
        checks++; if (mcnt_a !== 32'd5 || mcnt_b !== 32'd4) begin errors++; $display("FAIL top_mp got %0d/%0d want 5/4", mcnt_a, mcnt_b); end
        do_update(32'h100, 1'b0, 32'h0);
        checks++; if (taken_a !== 1'b1) begin errors++; $display("FAIL top_down_a got %0b want 1", taken_a); end
        checks++; if (taken_b !== 1'b0) begin errors++; $display("FAIL top_down_b got %0b want 0", taken_b); end
        checks++; if (mcnt_a !== 32'd6 || mcnt_b !== 32'd5 || ucnt_a !== 32'd9) begin errors++; $display("FAIL top_cnt got %0d/%0d/%0d want 6/5/9", mcnt_a, mcnt_b, ucnt_a); end
    endtask

    task automatic test_alias();
        do_update(32'h200, 1'b1, 32'h40);
        if_pc = 32'h100; #1;
        checks++; if (hit_a !== 1'b0 || taken_a !== 1'b0 || tgt_a !== 32'h0) begin errors++; $display("FAIL alias_old_a got %0b/%0b/%h want 0/0/0", hit_a, taken_a, tgt_a); end
        checks++; if (hit_b !== 1'b0 || tgt_b !== 32'h0) begin errors++; $display("FAIL alias_old_b got %0b/%h want 0/0", hit_b, tgt_b); end
        if_pc = 32'h200; #1;
        checks++; if (hit_a !== 1'b1 || taken_a !== 1'b1 || tgt_a !== 32'h40) begin errors++; $display("FAIL alias_new_a got %0b/%0b/%h want 1/1/40", hit_a, taken_a, tgt_a); end
        checks++; if (hit_b !== 1'b1 || taken_b !== 1'b1 || tgt_b !== 32'h40) begin errors++; $display("FAIL alias_new_b got %0b/%0b/%h want 1/1/40", hit_b, taken_b, tgt_b); end
        if_pc = 32'h202; #1;
        checks++; if (hit_a !== 1'b1 || hit_b !== 1'b1) begin errors++; $display("FAIL low_bits got %0b/%0b want 1/1", hit_a, hit_b); end
        checks++; if (mcnt_a !== 32'd7 || mcnt_b !== 32'd6 || ucnt_b !== 32'd10) begin errors++; $display("FAIL alias_cnt got %0d/%0d/%0d want 7/6/10", mcnt_a, mcnt_b, ucnt_b); end
        // Miss and not-taken leaves the table alone.
        do_update(32'h300, 1'b0, 32'h0);
        if_pc = 32'h200; #1;
        checks++; if (hit_a !== 1'b1 || hit_b !== 1'b1 || tgt_a !== 32'h40) begin errors++; $display("FAIL miss_nt got %0b/%0b/%h want 1/1/40", hit_a, hit_b, tgt_a); end
        checks++; if (mcnt_a !== 32'd7 || ucnt_a !== 32'd11) begin errors++; $display("FAIL miss_nt_cnt got %0d/%0d want 7/11", mcnt_a, ucnt_a); end
    endtask

    task automatic test_reset_priority();
        if_pc = 32'h200;
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h44;
        tick();
        rst = 1'b0; upd_valid = 1'b0;
        #1;
        checks++; if (hit_a !== 1'b0 || hit_b !== 1'b0 || tgt_a !== 32'h0) begin errors++; $display("FAIL rstpri_pred got %0b/%0b/%h want 0/0/0", hit_a, hit_b, tgt_a); end
        checks++; if (ucnt_a !== 32'd0 || ucnt_b !== 32'd0) begin errors++; $display("FAIL rstpri_upd got %0d/%0d want 0/0", ucnt_a, ucnt_b); end
        checks++; if (mcnt_a !== 32'd0 || mcnt_b !== 32'd0) begin errors++; $display("FAIL rstpri_mp got %0d/%0d want 0/0", mcnt_a, mcnt_b); end
    endtask

    initial begin
        test_reset();
        if_pc = 32'h100;
        test_train();
        test_not_taken_saturate();
        test_taken_recover();
        test_same_cycle();
        test_target_and_top();
        test_alias();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
